// File: rtl/mem_pkg.sv
// Shared packet-buffer memory types and sizing.
// The free-list index type and the count width are derived from the buffer size.
package mem_pkg;

    localparam int unsigned NUM_BLOCKS = 4096;
    localparam int unsigned ADDR_W     = $clog2(NUM_BLOCKS);
    localparam int unsigned FREE_CNT_W = ADDR_W + 1;

    typedef logic [ADDR_W-1:0] blk_idx_t;

    typedef enum logic {
        FL_INIT = 1'b0,
        FL_RUN  = 1'b1
    } fl_state_t;

endpackage

// File: rtl/free_idx_ram.sv
// Storage array for the free-index FIFO.
// It has one synchronous write port and one asynchronous read port, and its contents are not reset.
module free_idx_ram #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_free_list.sv
// Pool of free cell indices for the shared packet buffer.
// After reset it loads every index in order. It then serves alloc pops and free pushes in FIFO order.
module mem_free_list
    import mem_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS = mem_pkg::NUM_BLOCKS,
    parameter int unsigned ADDR_W     = mem_pkg::ADDR_W,
    parameter int unsigned LOW_WM     = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,
    output logic              alloc_valid,
    input  logic              alloc_ready,
    output logic [ADDR_W-1:0] alloc_idx,
    input  logic              free_valid,
    output logic              free_ready,
    input  logic [ADDR_W-1:0] free_idx,
    output logic [ADDR_W:0]   free_count,
    output logic              low_wm,
    output logic              err_overflow
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    if (NUM_BLOCKS != (1 << ADDR_W)) begin : g_bad_size
        $error("mem_free_list: NUM_BLOCKS must equal 2**ADDR_W");
    end

    fl_state_t         state, state_nxt;
    logic [ADDR_W-1:0] rd_ptr, rd_nxt;
    logic [ADDR_W-1:0] wr_ptr, wr_nxt;
    logic [ADDR_W-1:0] init_cnt, init_cnt_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              err_q, err_nxt;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [ADDR_W-1:0] ram_wdata;
    logic              pop, push;
    logic              running;
    logic              pool_empty, pool_full;

    free_idx_ram #(
        .DEPTH  (NUM_BLOCKS),
        .DATA_W (ADDR_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_ptr),
        .rdata (alloc_idx)
    );

    // Status decoded from the registered count and state only.
    assign running      = (state == FL_RUN);
    assign pool_empty   = (count == '0);
    assign pool_full    = (count == CNT_W'(NUM_BLOCKS));
    assign init_done    = running;
    assign alloc_valid  = running && !pool_empty;
    assign free_ready   = running && !pool_full;
    assign low_wm       = running && (count <= CNT_W'(LOW_WM));
    assign free_count   = count;
    assign err_overflow = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FL_INIT;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            init_cnt <= '0;
            count    <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_ptr   <= rd_nxt;
            wr_ptr   <= wr_nxt;
            init_cnt <= init_cnt_nxt;
            count    <= count_nxt;
            err_q    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rd_nxt       = rd_ptr;
        wr_nxt       = wr_ptr;
        init_cnt_nxt = init_cnt;
        count_nxt    = count;
        err_nxt      = err_q;
        ram_we       = 1'b0;
        ram_waddr    = wr_ptr;
        ram_wdata    = free_idx;
        pop          = 1'b0;
        push         = 1'b0;

        unique case (state)
            FL_INIT: begin
                // Identity fill; wr_ptr tracks init_cnt and wraps back to 0 on the last write.
                ram_we       = 1'b1;
                ram_waddr    = init_cnt;
                ram_wdata    = init_cnt;
                wr_nxt       = wr_ptr + ADDR_W'(1);
                init_cnt_nxt = init_cnt + ADDR_W'(1);
                count_nxt    = count + CNT_W'(1);
                if (init_cnt == ADDR_W'(NUM_BLOCKS - 1)) begin
                    state_nxt = FL_RUN;
                end
            end
            FL_RUN: begin
                pop  = alloc_valid && alloc_ready;
                push = free_valid && free_ready;
                if (free_valid && pool_full) begin
                    err_nxt = 1'b1;
                end
                if (pop) begin
                    rd_nxt = rd_ptr + ADDR_W'(1);
                end
                if (push) begin
                    ram_we = 1'b1;
                    wr_nxt = wr_ptr + ADDR_W'(1);
                end
                if (pop && !push) begin
                    count_nxt = count - CNT_W'(1);
                end else if (push && !pop) begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            default: state_nxt = FL_INIT;
        endcase
    end

endmodule
